serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_if.sv | 28 ++
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake and data bundle for the bit-serial add sequencer.
// The request side carries the operands in. The response side carries sum and carry-out back.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    // The producer/consumer side, which drives operands and accepts results.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    // The sequencer side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer. A single 1-bit full adder is built from two half_addr cells and an OR.
// It is time-shared LSB first over WIDTH cycles.

// One half-adder cell. This is the only arithmetic primitive the sequencer uses.
module half_addr (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);
    // The counter holds 0..WIDTH. It is sized so the final increment never wraps.
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] sumSh_q, sumSh_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             halfSum;
    logic             carry1;
    logic             bitSum;
    logic             carry2;

    // First cell adds the two operand LSBs.
    // The second cell folds in the running carry.
    half_addr uHa1 (
        .a_i (aSh_q[0]),
        .b_i (bSh_q[0]),
        .s_o (halfSum),
        .c_o (carry1)
    );

    half_addr uHa2 (
        .a_i (halfSum),
        .b_i (c_q),
        .s_o (bitSum),
        .c_o (carry2)
    );

    // State and datapath registers. Reset aborts any operation in flight and clears the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            sumSh_q <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            sumSh_q <= sumSh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath logic.
    // Operands are only sampled on an accepted request, so X on idle inputs never reaches state.
    always_comb begin
        state_d = state_q;
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        sumSh_d = sumSh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    aSh_d   = bus.a;
                    bSh_d   = bus.b;
                    c_d     = bus.cin;
                    cnt_d   = '0;
                    sumSh_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                c_d                = carry1 | carry2;
                sumSh_d            = sumSh_q >> 1;
                sumSh_d[WIDTH-1]   = bitSum;
                aSh_d              = aSh_q >> 1;
                bSh_d              = bSh_q >> 1;
                cnt_d              = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.sum       = sumSh_q;
    assign bus.cout      = c_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl. It uses an 8-bit instance for most scenarios and a 1-bit instance for the degenerate width.
// Expected results come from plain integer addition and the documented cycle timing.
module tb_serial_add_ctrl;
    logic clk;
    logic rst_n;
    int   cycle;
    int   checks;
    int   errors;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to time acceptances against each other.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // Hard stop in case anything unexpectedly stalls the sequence.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issues one operation on the 8-bit instance and waits for its result.
    // It holds the result for 'stall' extra cycles, then releases it. It returns the observations to the caller.
    task automatic applyStimulus(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                                 input int stall, output logic [7:0] so, output logic co,
                                 output int lat, output int acceptAt, output bit timeout,
                                 output bit heldOk);
        int guard;
        timeout = 1'b0;
        heldOk  = 1'b1;
        lat     = 0;
        guard   = 0;
        bus8.out_ready = (stall == 0);
        while (bus8.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) timeout = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.a        = ai;
        bus8.b        = bi;
        bus8.cin      = ci;
        acceptAt      = cycle;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.a        = 'x;
        bus8.b        = 'x;
        bus8.cin      = 'x;
        while (bus8.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (bus8.out_valid !== 1'b1) timeout = 1'b1;
        so = bus8.sum;
        co = bus8.cout;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (bus8.sum !== so || bus8.cout !== co || bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0)
                heldOk = 1'b0;
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
    endtask

    // Reset values on both instances while reset is held.
    task automatic test_reset();
        checks++;
        if ({bus8.in_ready, bus8.out_valid, bus8.busy, bus8.cout, bus8.sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset8: got rdy/vld/busy/cout/sum=%b%b%b%b/%h, expected 1000/00",
                     bus8.in_ready, bus8.out_valid, bus8.busy, bus8.cout, bus8.sum);
        end
        checks++;
        if ({bus1.in_ready, bus1.out_valid, bus1.busy, bus1.cout, bus1.sum} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset1: got rdy/vld/busy/cout/sum=%b%b%b%b%b, expected 10000",
                     bus1.in_ready, bus1.out_valid, bus1.busy, bus1.cout, bus1.sum);
        end
    endtask

    // Directed additions, including a carry rippling across every bit.
    task automatic test_directed();
        logic [7:0] av [3] = '{8'h00, 8'hFF, 8'h12};
        logic [7:0] bv [3] = '{8'h01, 8'h01, 8'h34};
        logic       cv [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] so;
        logic       co;
        logic [8:0] exp;
        int         lat, acc;
        bit         tmo, held;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(av[i], bv[i], cv[i], 0, so, co, lat, acc, tmo, held);
            exp = {1'b0, av[i]} + {1'b0, bv[i]} + {8'h00, cv[i]};
            checks++;
            if (tmo || {co, so} !== exp) begin
                errors++;
                $display("[TB] FAIL directed%0d: got cout/sum=%b/%h timeout=%0d, expected %b/%h",
                         i, co, so, tmo, exp[8], exp[7:0]);
            end
            checks++;
            if (lat != 8) begin
                errors++;
                $display("[TB] FAIL latency%0d: got %0d cycles, expected 8", i, lat);
            end
            checks++;
            if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL release%0d: got vld/rdy=%b%b, expected 01", i, bus8.out_valid, bus8.in_ready);
            end
        end
    endtask

    // Two operations issued back to back. The second is accepted 10 cycles after the first.
    task automatic test_back_to_back();
        logic [7:0] so1, so2;
        logic       co1, co2;
        int         lat1, lat2, acc1, acc2;
        bit         tmo1, tmo2, held;
        applyStimulus(8'hFF, 8'hFF, 1'b1, 0, so1, co1, lat1, acc1, tmo1, held);
        applyStimulus(8'h5A, 8'hA5, 1'b0, 0, so2, co2, lat2, acc2, tmo2, held);
        checks++;
        if (tmo1 || {co1, so1} !== 9'h1FF) begin
            errors++;
            $display("[TB] FAIL b2b_first: got %b/%h, expected 1/ff", co1, so1);
        end
        checks++;
        if (tmo2 || {co2, so2} !== 9'h0FF) begin
            errors++;
            $display("[TB] FAIL b2b_second: got %b/%h, expected 0/ff", co2, so2);
        end
        checks++;
        if (acc2 - acc1 != 10) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles, expected 10", acc2 - acc1);
        end
    endtask

    // Result held under backpressure, with a stray request ignored.
    // A request that collides with the release edge is taken one edge later.
    task automatic test_backpressure();
        int  lat;
        bit  ok;
        lat = 0;
        ok  = 1'b1;
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.a = 8'h12;
        bus8.b = 8'h34;
        bus8.cin = 1'b0;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        while (bus8.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("[TB] FAIL bp_latency: got %0d, expected 8", lat);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus8.in_valid = 1'b1;
                bus8.a = 8'h99;
                bus8.b = 8'h99;
            end else begin
                bus8.in_valid = 1'b0;
            end
            if (bus8.sum !== 8'h46 || bus8.cout !== 1'b0 || bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0)
                ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!ok || bus8.sum !== 8'h46 || bus8.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_hold: got sum=%h vld=%b, expected 46 held with vld=1", bus8.sum, bus8.out_valid);
        end
        bus8.in_valid  = 1'b1;
        bus8.a         = 8'h03;
        bus8.b         = 8'h04;
        bus8.cin       = 1'b1;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.sum !== 8'h46) begin
            errors++;
            $display("[TB] FAIL collide_idle: got rdy/vld/sum=%b%b/%h, expected 10/46",
                     bus8.in_ready, bus8.out_valid, bus8.sum);
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        checks++;
        if (bus8.in_ready !== 1'b0 || bus8.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collide_accept: got rdy/busy=%b%b, expected 01", bus8.in_ready, bus8.busy);
        end
        lat = 0;
        while (bus8.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 8 || {bus8.cout, bus8.sum} !== 9'h008) begin
            errors++;
            $display("[TB] FAIL collide_result: got %b/%h lat=%0d, expected 0/08 lat=8", bus8.cout, bus8.sum, lat);
        end
        @(negedge clk);
    endtask

    // Reset in the middle of RUN aborts the operation with no result.
    task automatic test_reset_midrun();
        logic [7:0] so;
        logic       co;
        int         lat, acc, seen;
        bit         tmo, held;
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        bus8.a = 8'h80;
        bus8.b = 8'h80;
        bus8.cin = 1'b0;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus8.in_ready, bus8.out_valid, bus8.busy, bus8.cout, bus8.sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL midrun_reset: got rdy/vld/busy/cout/sum=%b%b%b%b/%h, expected 1000/00",
                     bus8.in_ready, bus8.out_valid, bus8.busy, bus8.cout, bus8.sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.out_valid === 1'b1 || bus8.in_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL midrun_quiet: got %0d non-idle cycles, expected 0", seen);
        end
        applyStimulus(8'h80, 8'h80, 1'b0, 0, so, co, lat, acc, tmo, held);
        checks++;
        if (tmo || {co, so} !== 9'h100) begin
            errors++;
            $display("[TB] FAIL midrun_next: got %b/%h, expected 1/00", co, so);
        end
    endtask

    // Random operands and stall lengths checked against integer addition.
    task automatic test_random();
        logic [7:0] ai, bi, so;
        logic       ci, co;
        logic [8:0] exp;
        int         lat, acc, stall;
        bit         tmo, held;
        for (int i = 0; i < 24; i++) begin
            ai    = 8'($urandom);
            bi    = 8'($urandom);
            ci    = 1'($urandom);
            stall = $urandom_range(0, 3);
            applyStimulus(ai, bi, ci, stall, so, co, lat, acc, tmo, held);
            exp = {1'b0, ai} + {1'b0, bi} + {8'h00, ci};
            checks++;
            if (tmo || !held || lat != 8 || {co, so} !== exp) begin
                errors++;
                $display("[TB] FAIL random%0d: %h+%h+%b got %b/%h lat=%0d held=%0d, expected %b/%h lat=8 held=1",
                         i, ai, bi, ci, co, so, lat, held, exp[8], exp[7:0]);
            end
        end
    endtask

    // Degenerate width: one RUN edge, result one cycle after acceptance.
    task automatic test_width1();
        logic av [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic bv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic cv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0] exp;
        int         lat;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus1.in_valid = 1'b1;
            bus1.a   = av[i];
            bus1.b   = bv[i];
            bus1.cin = cv[i];
            @(negedge clk);
            bus1.in_valid = 1'b0;
            lat = 0;
            while (bus1.out_valid !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            exp = {1'b0, av[i]} + {1'b0, bv[i]} + {1'b0, cv[i]};
            checks++;
            if (lat != 1 || {bus1.cout, bus1.sum} !== exp) begin
                errors++;
                $display("[TB] FAIL width1_%0d: got %b%b lat=%0d, expected %b lat=1",
                         i, bus1.cout, bus1.sum, lat, exp);
            end
            @(negedge clk);
        end
    endtask

    // Scenario sequence.
    initial begin
        checks = 0;
        errors = 0;
        cycle  = 0;
        rst_n  = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus8.cin = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b0;
        bus1.a = '0;
        bus1.b = '0;
        bus1.cin = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midrun();
        test_random();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
